// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image over a byte stream, packs little-endian
// words into instruction memory and releases the core only after the checksum verifies.
module imem_boot_loader #(
  parameter int INST_DEPTH = 1024,
  parameter int TIMEOUT    = 100000,
  localparam int ADDR_W    = (INST_DEPTH > 1) ? $clog2(INST_DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err
);

  localparam int              TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [31:0]     DEPTH_32 = 32'(INST_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [7:0]        r_csum;
  logic [31:0]       r_len;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_word_addr;
  logic [TO_W-1:0]   r_gap;
  logic              r_rx_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_core_rst_n;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_err;

  logic              w_loading;
  logic              w_accept;
  logic              w_timeout;
  logic [31:0]       w_len_full;
  logic [31:0]       w_word_full;
  logic              w_len_bad;
  logic              w_last_word;

  assign w_loading   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_accept    = i_rx_valid & r_rx_ready;
  // The gap limit wins over a byte arriving on the same edge; that byte is dropped.
  assign w_timeout   = (TIMEOUT > 0) && w_loading && (r_gap == TO_LAST);
  assign w_len_full  = {i_rx_data, r_len[23:0]};
  assign w_word_full = {i_rx_data, r_word};
  assign w_len_bad   = (w_len_full == 32'd0) || (w_len_full > DEPTH_32);
  assign w_last_word = ((32'(r_word_addr) + 32'd1) == r_len);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_csum       <= 8'd0;
      r_len        <= 32'd0;
      r_word       <= 24'd0;
      r_word_addr  <= '0;
      r_gap        <= '0;
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 2'd0;
    end else begin
      r_imem_we <= 1'b0;
      if (w_loading) begin
        r_gap <= w_accept ? '0 : r_gap + TO_W'(1);
      end
      if (w_timeout) begin
        r_state    <= S_ERR;
        r_err      <= 2'd3;
        r_busy     <= 1'b0;
        r_rx_ready <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (i_start) begin
              r_state      <= S_LEN;
              r_byte_cnt   <= 2'd0;
              r_csum       <= 8'd0;
              r_word_addr  <= '0;
              r_gap        <= '0;
              r_err        <= 2'd0;
              r_done       <= 1'b0;
              r_busy       <= 1'b1;
              r_core_rst_n <= 1'b0;
              r_rx_ready   <= 1'b1;
            end
          end
          S_LEN: begin
            if (w_accept) begin
              r_csum     <= r_csum ^ i_rx_data;
              r_byte_cnt <= r_byte_cnt + 2'd1;
              case (r_byte_cnt)
                2'd0:    r_len[7:0]   <= i_rx_data;
                2'd1:    r_len[15:8]  <= i_rx_data;
                2'd2:    r_len[23:16] <= i_rx_data;
                default: r_len        <= w_len_full;
              endcase
              if (r_byte_cnt == 2'd3) begin
                if (w_len_bad) begin
                  r_state    <= S_ERR;
                  r_err      <= 2'd1;
                  r_busy     <= 1'b0;
                  r_rx_ready <= 1'b0;
                end else begin
                  r_state     <= S_DATA;
                  r_word_addr <= '0;
                end
              end
            end
          end
          S_DATA: begin
            if (w_accept) begin
              r_csum     <= r_csum ^ i_rx_data;
              r_byte_cnt <= r_byte_cnt + 2'd1;
              case (r_byte_cnt)
                2'd0:    r_word[7:0]   <= i_rx_data;
                2'd1:    r_word[15:8]  <= i_rx_data;
                2'd2:    r_word[23:16] <= i_rx_data;
                default: r_word        <= r_word;
              endcase
              if (r_byte_cnt == 2'd3) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_word_addr;
                r_imem_wdata <= w_word_full;
                // The address stops on the last word so it never wraps past the top.
                if (w_last_word) begin
                  r_state <= S_CSUM;
                end else begin
                  r_word_addr <= r_word_addr + ADDR_W'(1);
                end
              end
            end
          end
          S_CSUM: begin
            if (w_accept) begin
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              if (i_rx_data == r_csum) begin
                r_state      <= S_DONE;
                r_done       <= 1'b1;
                r_core_rst_n <= 1'b1;
              end else begin
                r_state <= S_ERR;
                r_err   <= 2'd2;
              end
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_core_rst_n = r_core_rst_n;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a table of whole frames with expected writes and
// status, plus hand-written sequences for timeout, reset, restart and full-depth loads.
module tb_imem_boot_loader;

  localparam int DEPTH  = 64;
  localparam int TMO    = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start;
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_rx_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;
  logic              o_core_rst_n;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_err;

  imem_boot_loader #(.INST_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_rx_ready   (o_rx_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_core_rst_n (o_core_rst_n),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    int          nb;
    logic [127:0] frame;   // bytes in send order, first byte most significant
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [1:0]  err;
    logic        done;
  } vec_t;

  vec_t        vecs[6];
  int          checks;
  int          errors;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  // Capture every memory write strobe away from the active edge.
  always @(negedge i_clk) begin
    if (o_imem_we) begin
      wr_a.push_back(32'(o_imem_addr));
      wr_d.push_back(o_imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    if (gap > 0) begin
      i_rx_valid = 1'b0;
      repeat (gap) @(negedge i_clk);
    end
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tries      = 0;
    while (!o_rx_ready && tries < 40) begin
      @(negedge i_clk);
      tries++;
    end
    if (!o_rx_ready) chk("rx_ready_wait", 32'(o_rx_ready), 32'd1);
    @(negedge i_clk);
  endtask

  task automatic run_vec(input vec_t v, input bit with_start);
    wr_a.delete();
    wr_d.delete();
    if (with_start) do_start();
    for (int i = 0; i < v.nb; i++) send_byte(v.frame[8*(v.nb-1-i) +: 8], 0);
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    chk({v.name, "_err"},    32'(o_err),        32'(v.err));
    chk({v.name, "_done"},   32'(o_done),       32'(v.done));
    chk({v.name, "_core"},   32'(o_core_rst_n), 32'(v.done));
    chk({v.name, "_busy"},   32'(o_busy),       32'd0);
    chk({v.name, "_ready"},  32'(o_rx_ready),   32'd0);
    chk({v.name, "_nwr"},    32'(wr_a.size()),  32'(v.nw));
    if (v.nw >= 1 && wr_a.size() >= 1) begin
      chk({v.name, "_a0"}, wr_a[0], 32'd0);
      chk({v.name, "_d0"}, wr_d[0], v.w0);
    end
    if (v.nw >= 2 && wr_a.size() >= 2) begin
      chk({v.name, "_a1"}, wr_a[1], 32'd1);
      chk({v.name, "_d1"}, wr_d[1], v.w1);
    end
    if (v.nw >= 1) begin
      chk({v.name, "_hold_a"}, 32'(o_imem_addr), 32'(v.nw - 1));
      chk({v.name, "_hold_d"}, o_imem_wdata, (v.nw >= 2) ? v.w1 : v.w0);
    end
  endtask

  function automatic logic [31:0] full_word(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {b ^ 8'h5A, 8'hC3, b, ~b};
  endfunction

  initial begin
    logic [7:0]  cs;
    logic [31:0] wd;
    int          gap;

    checks = 0;
    errors = 0;
    vecs[0] = '{"good2",   13, 128'h02000000_13000000_93001000_92, 2, 32'h00000013, 32'h00100093, 2'd0, 1'b1};
    vecs[1] = '{"badcsum", 13, 128'h02000000_13000000_93001000_00, 2, 32'h00000013, 32'h00100093, 2'd2, 1'b0};
    vecs[2] = '{"len0",     4, 128'h00000000,                      0, 32'h0,        32'h0,        2'd1, 1'b0};
    vecs[3] = '{"lenover",  4, 128'h41000000,                      0, 32'h0,        32'h0,        2'd1, 1'b0};
    vecs[4] = '{"lenhuge",  4, 128'h00000080,                      0, 32'h0,        32'h0,        2'd1, 1'b0};
    vecs[5] = '{"good1",    9, 128'h01000000_EFBEADDE_23,          1, 32'hDEADBEEF, 32'h0,        2'd0, 1'b1};

    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'd0;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(o_rx_ready),   32'd0);
    chk("rst_we",    32'(o_imem_we),    32'd0);
    chk("rst_addr",  32'(o_imem_addr),  32'd0);
    chk("rst_wdata", o_imem_wdata,      32'd0);
    chk("rst_core",  32'(o_core_rst_n), 32'd0);
    chk("rst_busy",  32'(o_busy),       32'd0);
    chk("rst_done",  32'(o_done),       32'd0);
    chk("rst_err",   32'(o_err),        32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1);

    // start with a byte already valid: the byte must not be taken
    @(negedge i_clk);
    i_start    = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hAA;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("sv_ready", 32'(o_rx_ready), 32'd1);
    chk("sv_busy",  32'(o_busy),     32'd1);
    chk("sv_err",   32'(o_err),      32'd0);
    run_vec(vecs[0], 1'b0);

    // restart from DONE holds the core again on the next cycle, then LEN times out
    do_start();
    chk("rs_core",  32'(o_core_rst_n), 32'd0);
    chk("rs_done",  32'(o_done),       32'd0);
    chk("rs_busy",  32'(o_busy),       32'd1);
    repeat (TMO) @(negedge i_clk);
    chk("rs_tmo_err", 32'(o_err), 32'd3);

    // timeout exactly TMO cycles after the last accepted byte
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    i_rx_valid = 1'b0;
    repeat (TMO - 1) @(negedge i_clk);
    chk("tmo_early_err",  32'(o_err),  32'd0);
    chk("tmo_early_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    chk("tmo_err",   32'(o_err),      32'd3);
    chk("tmo_busy",  32'(o_busy),     32'd0);
    chk("tmo_ready", 32'(o_rx_ready), 32'd0);

    // full depth: back-to-back first half, random gaps second half
    wr_a.delete();
    wr_d.delete();
    do_start();
    cs = 8'h40;
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    for (int w = 0; w < DEPTH; w++) begin
      wd = full_word(w);
      for (int k = 0; k < 4; k++) begin
        gap = (w < DEPTH / 2) ? 0 : int'($urandom_range(0, 4));
        send_byte(wd[8*k +: 8], gap);
        cs = cs ^ wd[8*k +: 8];
      end
    end
    send_byte(cs, 0);
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    chk("full_done", 32'(o_done),       32'd1);
    chk("full_core", 32'(o_core_rst_n), 32'd1);
    chk("full_err",  32'(o_err),        32'd0);
    chk("full_nwr",  32'(wr_a.size()),  32'(DEPTH));
    for (int w = 0; w < DEPTH; w++) begin
      if (w < wr_a.size()) begin
        chk("full_addr", wr_a[w], 32'(w));
        chk("full_data", wr_d[w], full_word(w));
      end
    end

    // reset in the middle of a word: immediate reset values, no write afterwards
    wr_a.delete();
    wr_d.delete();
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    i_rx_valid = 1'b0;
    i_rst_n    = 1'b0;
    #1;
    chk("mr_busy",  32'(o_busy),       32'd0);
    chk("mr_ready", 32'(o_rx_ready),   32'd0);
    chk("mr_core",  32'(o_core_rst_n), 32'd0);
    chk("mr_addr",  32'(o_imem_addr),  32'd0);
    chk("mr_wdata", o_imem_wdata,      32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("mr_nwr",  32'(wr_a.size()), 32'd0);
    chk("mr_idle", 32'(o_busy),      32'd0);
    run_vec(vecs[0], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
